// File: rtl/pipe_pkg.sv
// Shared pipeline widths and the ID->EX payload bundle.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;
    localparam int DEST_W_DEF = 5;
    localparam int CMD_W_DEF  = 4;

    typedef struct packed {
        logic [DEST_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] val1;
        logic [DATA_W_DEF-1:0] val2;
        logic [DATA_W_DEF-1:0] reg2;
        logic [PC_W_DEF-1:0]   pc;
        logic [CMD_W_DEF-1:0]  exe_cmd;
        logic                  br_taken;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
    } id_ex_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; in_ready is a flop so
// there is no combinational out_ready->in_ready path.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic         rdy_q;
    logic         in_fire;

    assign in_fire   = in_valid & rdy_q;
    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_ready) begin
            // skid entry is older than any new input, so it drains first
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (in_fire) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= ~skid_v_d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with flush, bubble gating and stall counter.
// Define ID_EX_SKID_EN for a registered-ready two-entry skid buffer.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter int CMD_W  = CMD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] val1_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] reg2_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic              br_taken_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] reg2,
    output logic [PC_W-1:0]   pc,
    output logic [CMD_W-1:0]  exe_cmd,
    output logic              br_taken,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic [15:0]       stall_cnt
);

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
        logic [PC_W-1:0]   pc;
        logic [CMD_W-1:0]  exe_cmd;
        logic              br_taken;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
    } pay_t;

    localparam int PAY_W = $bits(pay_t);

    pay_t pay_in;
    pay_t pay_q;
    logic vld_q;

    assign pay_in = '{
        dest:     dest_in,
        val1:     val1_in,
        val2:     val2_in,
        reg2:     reg2_in,
        pc:       pc_in,
        exe_cmd:  exe_cmd_in,
        br_taken: br_taken_in,
        mem_r_en: mem_r_en_in,
        mem_w_en: mem_w_en_in,
        wb_en:    wb_en_in
    };

`ifdef ID_EX_SKID_EN
    logic [PAY_W-1:0] pay_vec;

    pipe_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (vld_q),
        .out_ready (out_ready),
        .out_data  (pay_vec)
    );

    assign pay_q = pay_t'(pay_vec);
`else
    assign in_ready = ~rst & (out_ready | ~vld_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pay_q <= '0;
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            pay_q <= pay_in;
            vld_q <= 1'b1;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end
`endif

    assign out_valid = vld_q;
    assign dest      = pay_q.dest;
    assign val1      = pay_q.val1;
    assign val2      = pay_q.val2;
    assign reg2      = pay_q.reg2;
    assign pc        = pay_q.pc;
    assign exe_cmd   = pay_q.exe_cmd;
    // side-effecting controls must read as a bubble when nothing is held
    assign br_taken  = pay_q.br_taken & vld_q;
    assign mem_r_en  = pay_q.mem_r_en & vld_q;
    assign mem_w_en  = pay_q.mem_w_en & vld_q;
    assign wb_en     = pay_q.wb_en & vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (vld_q && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg against a queue-based model.
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] stall_cnt;
    id_ex_t      cur;
    id_ex_t      obs;

    logic [4:0]  dest;
    logic [31:0] val1, val2, reg2, pc;
    logic [3:0]  exe_cmd;
    logic        br_taken, mem_r_en, mem_w_en, wb_en;

    id_ex_t q[$];
    int     model_stall;
    int     n_cmp;
    int     n_bad;

    id_ex_pipe_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .dest_in     (cur.dest),
        .val1_in     (cur.val1),
        .val2_in     (cur.val2),
        .reg2_in     (cur.reg2),
        .pc_in       (cur.pc),
        .exe_cmd_in  (cur.exe_cmd),
        .br_taken_in (cur.br_taken),
        .mem_r_en_in (cur.mem_r_en),
        .mem_w_en_in (cur.mem_w_en),
        .wb_en_in    (cur.wb_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dest        (dest),
        .val1        (val1),
        .val2        (val2),
        .reg2        (reg2),
        .pc          (pc),
        .exe_cmd     (exe_cmd),
        .br_taken    (br_taken),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .wb_en       (wb_en),
        .stall_cnt   (stall_cnt)
    );

    assign obs = '{
        dest: dest, val1: val1, val2: val2, reg2: reg2, pc: pc,
        exe_cmd: exe_cmd, br_taken: br_taken, mem_r_en: mem_r_en,
        mem_w_en: mem_w_en, wb_en: wb_en
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_ex_t rand_pay(input logic [31:0] p);
        id_ex_t      r;
        logic [31:0] b;
        b          = $urandom;
        r.dest     = b[4:0];
        r.exe_cmd  = b[8:5];
        r.br_taken = b[9];
        r.mem_r_en = b[10];
        r.mem_w_en = b[11];
        r.wb_en    = b[12];
        r.val1     = $urandom;
        r.val2     = $urandom;
        r.reg2     = $urandom;
        r.pc       = p;
        return r;
    endfunction

    // one clock: record handshakes, advance, update the model
    task automatic tick();
        bit fi, fo, st;
        #1;
        fi = (in_valid === 1'b1) && (in_ready === 1'b1);
        fo = (out_valid === 1'b1) && (out_ready === 1'b1);
        st = (out_valid === 1'b1) && (out_ready === 1'b0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            model_stall = 0;
        end else begin
            if (st && model_stall < 65535) model_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (fo && q.size() > 0) void'(q.pop_front());
                if (fi) q.push_back(cur);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cur       = rand_pay(32'h44);
        cur.wb_en = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (wb_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wb_en got %b want 0", wb_en);
        end
        n_cmp++;
        if (stall_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
        end
        n_cmp++;
        if (pc !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_pc got %h want 0", pc);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        id_ex_t sent;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur      = rand_pay(32'(i * 4));
            sent     = cur;
            in_valid = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== sent) begin
                n_bad++;
                $display("FAIL stream_out[%0d] valid %b pc %h want valid 1 pc %h",
                         i, out_valid, pc, sent.pc);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        id_ex_t snap;
        int     base;
        int     seen;
        logic [31:0] pcs [4];
        base      = model_stall;
        out_ready = 1'b0;
        cur       = rand_pay(32'h40);
        in_valid  = 1'b1;
        tick();
        snap = obs;
        n_cmp++;
        if (out_valid !== 1'b1 || pc !== 32'h40) begin
            n_bad++;
            $display("FAIL bp_first valid %b pc %h want 1 40", out_valid, pc);
        end
        for (int i = 0; i < 5; i++) begin
            cur = rand_pay(32'(32'h44 + 4 * i));
            #1;
            n_cmp++;
            if (in_ready !== (SKID && i == 0)) begin
                n_bad++;
                $display("FAIL bp_in_ready[%0d] got %b want %b",
                         i, in_ready, (SKID && i == 0));
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== snap) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] valid %b pc %h want 1 40", i, out_valid, pc);
            end
        end
        n_cmp++;
        if (stall_cnt !== 16'(base + 5)) begin
            n_bad++;
            $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, base + 5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid === 1'b1 && seen < 4) begin
                pcs[seen] = pc;
                seen++;
            end
            tick();
        end
        n_cmp++;
        if (seen !== (SKID ? 2 : 1)) begin
            n_bad++;
            $display("FAIL bp_drain_count got %0d want %0d", seen, SKID ? 2 : 1);
        end
        if (seen >= 1) begin
            n_cmp++;
            if (pcs[0] !== 32'h40) begin
                n_bad++;
                $display("FAIL bp_order0 got %h want 40", pcs[0]);
            end
        end
        if (seen >= 2) begin
            n_cmp++;
            if (pcs[1] !== 32'h44) begin
                n_bad++;
                $display("FAIL bp_order1 got %h want 44", pcs[1]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur = rand_pay(32'(32'h60 + 4 * i));
            cur.mem_w_en = 1'b1;
            tick();
        end
        cur          = rand_pay(32'h80);
        cur.mem_w_en = 1'b1;
        flush        = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (mem_w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_mem_w_en got %b want 0", mem_w_en);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_in_ready got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_ghost[%0d] valid %b pc %h want valid 0",
                         i, out_valid, pc);
            end
        end
    endtask

    task automatic test_random();
        id_ex_t prev_obs;
        bit     prev_stall;
        bit     prev_flush;
        bit     exp_rdy;
        prev_stall = 1'b0;
        prev_flush = 1'b0;
        prev_obs   = obs;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            cur       = rand_pay($urandom);
            #1;
            n_cmp++;
            if (out_valid !== (q.size() != 0)) begin
                n_bad++;
                $display("FAIL rnd_valid@%0d got %b want %b", c, out_valid, q.size() != 0);
            end
            if (out_valid === 1'b1 && q.size() != 0) begin
                n_cmp++;
                if (obs !== q[0]) begin
                    n_bad++;
                    $display("FAIL rnd_payload@%0d pc %h want %h", c, pc, q[0].pc);
                end
            end
            if (out_valid === 1'b0) begin
                n_cmp++;
                if ({br_taken, mem_r_en, mem_w_en, wb_en} !== 4'b0) begin
                    n_bad++;
                    $display("FAIL rnd_bubble@%0d ctl %b want 0000", c,
                             {br_taken, mem_r_en, mem_w_en, wb_en});
                end
            end
            exp_rdy = SKID ? (q.size() < 2) : (out_ready || q.size() == 0);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rnd_in_ready@%0d got %b want %b", c, in_ready, exp_rdy);
            end
            if (prev_stall && !prev_flush) begin
                n_cmp++;
                if (obs !== prev_obs) begin
                    n_bad++;
                    $display("FAIL rnd_stable@%0d pc %h want %h", c, pc, prev_obs.pc);
                end
            end
            n_cmp++;
            if (stall_cnt !== 16'(model_stall)) begin
                n_bad++;
                $display("FAIL rnd_stall_cnt@%0d got %0d want %0d", c, stall_cnt, model_stall);
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_flush = flush;
            prev_obs   = obs;
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        flush     = 1'b0;
        cur       = rand_pay(32'h100);
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_value got %h want ffff", stall_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_after_flush got %h want ffff", stall_cnt);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_flush_valid got %b want 0", out_valid);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        model_stall = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        cur         = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameters: DATA_W, 32, width of val1/val2/reg2; PC_W, 32, pc width; DEST_W, 5, destination register index width; CMD_W, 4, exe_cmd width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  ID payload valid; in_ready  out  1  stage accepts payload; flush  in  1  discard all held entries.
REQ-004 SHALL have payload inputs: dest_in  DEST_W; val1_in, val2_in, reg2_in  DATA_W; pc_in  PC_W; exe_cmd_in  CMD_W; br_taken_in, mem_r_en_in, mem_w_en_in, wb_en_in  1 each.
REQ-005 SHALL have outputs: out_valid  out  1  EXE payload valid; out_ready  in  1  EXE consumes payload; same-named payload outputs without _in suffix, same widths.
REQ-006 SHALL have output stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-007 SHALL transfer in on a cycle with in_valid & in_ready; SHALL transfer out on a cycle with out_valid & out_ready.
REQ-008 SHALL present an accepted payload on the outputs one cycle after acceptance when the stage was empty or drained that cycle (latency 1).
REQ-009 SHALL preserve payload order; no payload SHALL be lost, duplicated or reordered absent flush.
REQ-010 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-011 SHALL force br_taken, mem_r_en, mem_w_en, wb_en outputs to 0 whenever out_valid=0 (bubble safe); data fields undefined-but-stable when out_valid=0.
REQ-012 flush SHALL clear all held entries so out_valid=0 the next cycle; a payload offered in the flush cycle SHALL be discarded; flush SHALL override simultaneous in/out transfers.
REQ-013 Simultaneous in and out transfer with one entry held SHALL replace the entry; occupancy unchanged.
REQ-014 stall_cnt SHALL increment by 1 per stall cycle, saturate at 16'hFFFF, not clear on flush.

Reset
REQ-015 On rst=1 at a clock edge: out_valid=0, all payload outputs 0, stall_cnt=0, internal occupancy 0; rst SHALL dominate flush and transfers.
REQ-016 in_ready SHALL be 0 during and 1 the cycle after reset release (no skid: follows REQ-019).

Configuration
REQ-017 Macro ID_EX_SKID_EN SHALL select the buffering mode.
REQ-018 With ID_EX_SKID_EN defined: two-entry skid buffer; in_ready SHALL be a register output (=1 iff skid entry empty); full throughput with no combinational out_ready->in_ready path.
REQ-019 Without ID_EX_SKID_EN: single entry; in_ready = out_ready | ~out_valid combinationally; full throughput.
REQ-020 Both modes SHALL satisfy REQ-007..REQ-016 identically at the out side.

Structure
REQ-021 Shared package pipe_pkg SHALL hold the default width constants and the id_ex payload struct typedef (all fields of REQ-004).
REQ-022 One sub-module pipe_skid_buf (payload-width parametrised, generic valid/ready skid) SHALL be instantiated only under ID_EX_SKID_EN; stall counter and control gating stay in id_ex_pipe_reg.

Verification
REQ-023 Reset: drive rst 1 cycle with in_valid=1 -> out_valid=0, wb_en=0, stall_cnt=0, pc=0.
REQ-024 Stream: 8 payloads pc=0x00,0x04..0x1C, out_ready=1 -> emerge in order, 1 cycle latency, one per cycle.
REQ-025 Backpressure: out_ready=0 for 5 cycles holding pc=0x40 -> outputs stable, stall_cnt=5, no loss (skid mode: in_ready drops after 2nd entry, no-skid: after 1st).
REQ-026 Flush: 2 entries held plus in_valid=1 pc=0x80, flush=1 -> next cycle out_valid=0, mem_w_en=0; pc 0x80 never appears.
REQ-027 Saturation: force 70000 stall cycles -> stall_cnt=0xFFFF, stays after flush.
REQ-028 Random valid/ready 10k cycles in both ID_EX_SKID_EN modes -> scoreboard match, out stable under stall.
